// File: rtl/sd_cmd_arbiter_if.sv
// Signal bundle between the two command requesters, the arbiter and the SD command serial host.
// The slave modport is the arbiter's view; master is the surrounding logic driving it.
interface sd_cmd_arbiter_if;
    logic        a_start_i;
    logic        b_start_i;
    logic [15:0] a_setting_i;
    logic [15:0] b_setting_i;
    logic [39:0] a_cmd_i;
    logic [39:0] b_cmd_i;
    logic        a_busy_o;
    logic        b_busy_o;
    logic        a_done_o;
    logic        b_done_o;
    logic [39:0] resp_o;
    logic        crc_ok_o;
    logic        timeout_o;
    logic [15:0] host_setting_o;
    logic [39:0] host_cmd_o;
    logic        host_req_o;
    logic        host_ack_i;
    logic        host_req_i;
    logic [15:0] host_status_i;
    logic [39:0] host_resp_i;
    logic        host_ack_o;
    logic        host_go_idle_o;

    modport slave (
        input  a_start_i, b_start_i, a_setting_i, b_setting_i, a_cmd_i, b_cmd_i,
               host_ack_i, host_req_i, host_status_i, host_resp_i,
        output a_busy_o, b_busy_o, a_done_o, b_done_o, resp_o, crc_ok_o, timeout_o,
               host_setting_o, host_cmd_o, host_req_o, host_ack_o, host_go_idle_o
    );

    modport master (
        output a_start_i, b_start_i, a_setting_i, b_setting_i, a_cmd_i, b_cmd_i,
               host_ack_i, host_req_i, host_status_i, host_resp_i,
        input  a_busy_o, b_busy_o, a_done_o, b_done_o, resp_o, crc_ok_o, timeout_o,
               host_setting_o, host_cmd_o, host_req_o, host_ack_o, host_go_idle_o
    );
endinterface

// File: rtl/sd_cmd_arbiter.sv
// Round-robin arbiter of two command sources onto the SD command serial host: runs the
// REQ/ACK issue handshake, collects final status/response, and kicks GO_IDLE on timeout.
module sd_cmd_arbiter #(
    parameter int unsigned TIMEOUT = 4095
) (
    input  logic            SD_CLK_IN,
    input  logic            RST_IN,
    sd_cmd_arbiter_if.slave bus
);
    localparam logic [11:0] TIMEOUT_C = 12'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACK, ABORT, DONE} state_t;

    state_t      state_q, state_d;
    logic        grant_q, grant_d, last_grant_q;
    logic        load;
    logic        final_st;
    logic [11:0] timer_q, timer_inc;
    logic        pend_a_q, pend_b_q;
    logic [15:0] a_set_q, b_set_q;
    logic [39:0] a_cmd_q, b_cmd_q;
    logic        busy_a, busy_b, done_a, done_b, acc_a, acc_b;
    logic        req, ack, go_idle;
    logic [15:0] host_setting_q;
    logic [39:0] host_cmd_q, resp_q;
    logic        crc_ok_q, timeout_q;
    logic        unused_status;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        load      = 1'b0;
        final_st  = bus.host_req_i && bus.host_status_i[6];
        timer_inc = (timer_q == TIMEOUT_C) ? timer_q : timer_q + 12'd1;
        req       = (state_q == ISSUE);
        ack       = (state_q == ACK);
        go_idle   = (state_q == ABORT);
        done_a    = (state_q == DONE) && !grant_q;
        done_b    = (state_q == DONE) && grant_q;
        busy_a    = pend_a_q || ((state_q != IDLE) && !grant_q);
        busy_b    = pend_b_q || ((state_q != IDLE) && grant_q);
        // A start on the same cycle as that port's done pulse is a fresh command
        acc_a     = bus.a_start_i && (!busy_a || done_a);
        acc_b     = bus.b_start_i && (!busy_b || done_b);
        case (state_q)
            IDLE: begin
                if ((pend_a_q || pend_b_q) && bus.host_ack_i) begin
                    load    = 1'b1;
                    grant_d = (pend_a_q && pend_b_q) ? ~last_grant_q : pend_b_q;
                    state_d = ISSUE;
                end
            end
            ISSUE: if (!bus.host_ack_i) state_d = WAIT;
            WAIT: begin
                if (final_st)                    state_d = ACK;
                else if (timer_inc == TIMEOUT_C) state_d = ABORT;
            end
            ACK:     if (bus.host_ack_i) state_d = DONE;
            ABORT:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge SD_CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            if (load) last_grant_q <= grant_d;
        end
    end

    always_ff @(posedge SD_CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            pend_a_q       <= 1'b0;
            pend_b_q       <= 1'b0;
            a_set_q        <= '0;
            b_set_q        <= '0;
            a_cmd_q        <= '0;
            b_cmd_q        <= '0;
            timer_q        <= '0;
            host_setting_q <= '0;
            host_cmd_q     <= '0;
            resp_q         <= '0;
            crc_ok_q       <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            if (acc_a) begin
                pend_a_q <= 1'b1;
                a_set_q  <= bus.a_setting_i;
                a_cmd_q  <= bus.a_cmd_i;
            end else if (done_a) begin
                pend_a_q <= 1'b0;
            end
            if (acc_b) begin
                pend_b_q <= 1'b1;
                b_set_q  <= bus.b_setting_i;
                b_cmd_q  <= bus.b_cmd_i;
            end else if (done_b) begin
                pend_b_q <= 1'b0;
            end
            if (load) begin
                host_setting_q <= grant_d ? b_set_q : a_set_q;
                host_cmd_q     <= grant_d ? b_cmd_q : a_cmd_q;
            end
            if ((state_q == ISSUE) && (state_d == WAIT)) timer_q <= '0;
            else if (state_q == WAIT)                     timer_q <= timer_inc;
            if ((state_q == WAIT) && final_st) begin
                resp_q    <= bus.host_resp_i;
                crc_ok_q  <= bus.host_status_i[5];
                timeout_q <= 1'b0;
            end
            if (state_q == ABORT) begin
                crc_ok_q  <= 1'b0;
                timeout_q <= 1'b1;
            end
        end
    end

    assign unused_status      = ^{bus.host_status_i[15:7], bus.host_status_i[4:0]};

    assign bus.a_busy_o       = busy_a;
    assign bus.b_busy_o       = busy_b;
    assign bus.a_done_o       = done_a;
    assign bus.b_done_o       = done_b;
    assign bus.resp_o         = resp_q;
    assign bus.crc_ok_o       = crc_ok_q;
    assign bus.timeout_o      = timeout_q;
    assign bus.host_setting_o = host_setting_q;
    assign bus.host_cmd_o     = host_cmd_q;
    assign bus.host_req_o     = req;
    assign bus.host_ack_o     = ack;
    assign bus.host_go_idle_o = go_idle;
endmodule

// File: tb/tb_sd_cmd_arbiter.sv
// Scoreboard bench for sd_cmd_arbiter: directed commands against a behavioural command host.
module tb_sd_cmd_arbiter;
    logic clk = 1'b0;
    logic rst;

    sd_cmd_arbiter_if bus();

    sd_cmd_arbiter #(.TIMEOUT(16)) dut (
        .SD_CLK_IN (clk),
        .RST_IN    (rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct { bit port; logic [39:0] resp; bit crc; bit to; } res_t;
    typedef struct { logic [15:0] set; logic [39:0] cmd; } iss_t;

    res_t        rq[$];
    iss_t        iq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          req_rises = 0, ack_cycles = 0, goidle_cnt = 0, done_cnt = 0, wait_start = 0;
    logic        prev_req = 1'b0;
    logic [39:0] last_resp = '0;
    logic [15:0] hm_status = '0;
    logic [39:0] hm_resp = '0;
    bit          hm_hang = 1'b0;
    bit          hm_wo = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural host: ack drops 3 cycles after req, one intermediate status, then final status
    initial begin : host_model
        int cnt;
        cnt = 0;
        bus.host_ack_i    = 1'b1;
        bus.host_req_i    = 1'b0;
        bus.host_status_i = '0;
        bus.host_resp_i   = '0;
        forever begin
            tick();
            if (rst || bus.host_go_idle_o) begin
                bus.host_ack_i = 1'b1;
                bus.host_req_i = 1'b0;
                cnt = -1;
            end else if (cnt < 0) begin
                cnt = 0;
            end else if (bus.host_ack_i && !bus.host_req_i) begin
                if (bus.host_req_o) begin
                    cnt++;
                    if (cnt == 3) begin bus.host_ack_i = 1'b0; cnt = 100; end
                end
            end else if (!bus.host_req_i && cnt >= 100) begin
                cnt++;
                if (cnt == 102) begin
                    bus.host_req_i = 1'b1; bus.host_status_i = 16'h0020; bus.host_resp_i = 40'hDEADBEEF00;
                end else if (cnt == 106 && !hm_hang) begin
                    bus.host_req_i = 1'b1; bus.host_status_i = hm_status; bus.host_resp_i = hm_resp;
                    if (hm_wo) bus.host_ack_i = 1'b1;
                    cnt = 200;
                end
            end else if (bus.host_req_i && cnt < 200) begin
                cnt++;
                bus.host_req_i = 1'b0;
            end else if (bus.host_req_i && bus.host_ack_o) begin
                bus.host_req_i = 1'b0;
                bus.host_ack_i = 1'b1;
                cnt = 0;
            end
        end
    end

    initial begin : monitor
        res_t r;
        iss_t s;
        forever begin
            @(negedge clk);
            if (bus.host_req_o && !prev_req) begin
                req_rises++;
                if (iq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL issue_unexpected host_cmd=%h required=none", bus.host_cmd_o);
                end else begin
                    s = iq.pop_front();
                    chk("host_setting", 64'(bus.host_setting_o), 64'(s.set));
                    chk("host_cmd", 64'(bus.host_cmd_o), 64'(s.cmd));
                end
            end
            if (prev_req && !bus.host_req_o) wait_start = cyc;
            prev_req = bus.host_req_o;
            if (bus.host_ack_o) ack_cycles++;
            if (bus.host_go_idle_o) begin
                goidle_cnt++;
                chk("goidle_gap", 64'(cyc - wait_start), 64'd16);
            end
            if (bus.a_done_o || bus.b_done_o) begin
                done_cnt++;
                if (rq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL done_unexpected a_done=%0b b_done=%0b required=none", bus.a_done_o, bus.b_done_o);
                end else begin
                    r = rq.pop_front();
                    chk("done_port", 64'({bus.a_done_o, bus.b_done_o}), r.port ? 64'd1 : 64'd2);
                    chk("resp", 64'(bus.resp_o), 64'(r.resp));
                    chk("crc_ok", 64'(bus.crc_ok_o), 64'(r.crc));
                    chk("timeout", 64'(bus.timeout_o), 64'(r.to));
                end
            end
        end
    end

    task automatic host_cfg(input logic [15:0] st, input logic [39:0] rs, input bit hang, input bit wo);
        hm_status = st; hm_resp = rs; hm_hang = hang; hm_wo = wo;
    endtask

    task automatic push_issue(input logic [15:0] set, input logic [39:0] cmd);
        iss_t s;
        s.set = set; s.cmd = cmd;
        iq.push_back(s);
    endtask

    task automatic expect_cmd(input bit port, input logic [15:0] set, input logic [39:0] cmd);
        res_t r;
        push_issue(set, cmd);
        r.port = port;
        if (hm_hang) begin
            r.resp = last_resp; r.crc = 1'b0; r.to = 1'b1;
        end else begin
            r.resp = hm_resp; r.crc = hm_status[5]; r.to = 1'b0;
            last_resp = hm_resp;
        end
        rq.push_back(r);
    endtask

    task automatic pulse(input bit do_a, input bit do_b, input logic [15:0] sa, input logic [39:0] ca,
                         input logic [15:0] sb, input logic [39:0] cb);
        bus.a_setting_i = sa; bus.a_cmd_i = ca;
        bus.b_setting_i = sb; bus.b_cmd_i = cb;
        bus.a_start_i = do_a; bus.b_start_i = do_b;
        tick();
        bus.a_start_i = 1'b0; bus.b_start_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((bus.a_busy_o || bus.b_busy_o) && n < 300) begin tick(); n++; end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL wait_idle busy=%0b%0b after %0d cycles required=00", bus.a_busy_o, bus.b_busy_o, n);
        end
        tick();
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_ctl"}, 64'({bus.a_busy_o, bus.b_busy_o, bus.a_done_o, bus.b_done_o, bus.crc_ok_o,
                               bus.timeout_o, bus.host_req_o, bus.host_ack_o, bus.host_go_idle_o}), 64'd0);
        chk({nm, "_resp"}, 64'(bus.resp_o), 64'd0);
        chk({nm, "_hcmd"}, 64'(bus.host_cmd_o), 64'd0);
        chk({nm, "_hset"}, 64'(bus.host_setting_o), 64'd0);
    endtask

    initial begin : stimulus
        int n, snap;
        rst = 1'b1;
        bus.a_start_i = 1'b0; bus.b_start_i = 1'b0;
        bus.a_setting_i = '0; bus.b_setting_i = '0;
        bus.a_cmd_i = '0; bus.b_cmd_i = '0;
        repeat (3) tick();
        chk_zero("reset");
        rst = 1'b0;
        repeat (2) tick();

        // Simultaneous starts out of reset: A first, then B
        host_cfg(16'h0066, 40'h0123456789, 1'b0, 1'b0);
        expect_cmd(1'b0, 16'h0031, 40'h0A00000001);
        expect_cmd(1'b1, 16'h0032, 40'h0B00000002);
        pulse(1'b1, 1'b1, 16'h0031, 40'h0A00000001, 16'h0032, 40'h0B00000002);
        wait_idle();

        // Port B write-only command
        host_cfg(16'h0044, 40'h0000000000, 1'b0, 1'b1);
        expect_cmd(1'b1, 16'h0300, 40'h1800000000);
        req_rises = 0; ack_cycles = 0;
        pulse(1'b0, 1'b1, 16'h0000, 40'h0, 16'h0300, 40'h1800000000);
        wait_idle();
        chk("wo_req_phases", 64'(req_rises), 64'd1);
        chk("wo_ack_cycles", 64'(ack_cycles), 64'd1);

        // Port A read command
        host_cfg(16'h0066, 40'hA5A5A5A5A5, 1'b0, 1'b0);
        expect_cmd(1'b0, 16'h0030, 40'h1100000000);
        pulse(1'b1, 1'b0, 16'h0030, 40'h1100000000, 16'h0000, 40'h0);
        wait_idle();

        // Last grant was A, so this tie goes to B
        host_cfg(16'h0066, 40'h3C3C3C3C3C, 1'b0, 1'b0);
        expect_cmd(1'b1, 16'h0034, 40'h0B00000004);
        expect_cmd(1'b0, 16'h0033, 40'h0A00000003);
        pulse(1'b1, 1'b1, 16'h0033, 40'h0A00000003, 16'h0034, 40'h0B00000004);
        wait_idle();

        // Host never finishes: abort after 16 WAIT cycles
        host_cfg(16'h0000, 40'h0, 1'b1, 1'b0);
        expect_cmd(1'b0, 16'h0030, 40'h0D00000000);
        goidle_cnt = 0;
        pulse(1'b1, 1'b0, 16'h0030, 40'h0D00000000, 16'h0000, 40'h0);
        wait_idle();
        chk("goidle_pulses", 64'(goidle_cnt), 64'd1);

        // Final status with CRC bit clear
        host_cfg(16'h0046, 40'h5A5A5A5A5A, 1'b0, 1'b0);
        expect_cmd(1'b1, 16'h00B0, 40'h1200000007);
        pulse(1'b0, 1'b1, 16'h0000, 40'h0, 16'h00B0, 40'h1200000007);
        wait_idle();

        // Reset in the middle of WAIT
        host_cfg(16'h0000, 40'h0, 1'b1, 1'b0);
        push_issue(16'h0030, 40'h1300000000);
        goidle_cnt = 0;
        pulse(1'b0, 1'b1, 16'h0000, 40'h0, 16'h0030, 40'h1300000000);
        n = 0;
        while (!bus.host_req_o && n < 50) begin tick(); n++; end
        while (bus.host_req_o && n < 50) begin tick(); n++; end
        chk("rst_reach_wait", 64'(n < 50), 64'd1);
        repeat (4) tick();
        #2 rst = 1'b1;
        #1 chk_zero("rst_mid");
        snap = done_cnt;
        repeat (3) tick();
        rst = 1'b0;
        host_cfg(16'h0066, 40'h00000000FF, 1'b0, 1'b0);
        last_resp = '0;
        repeat (20) tick();
        chk("rst_no_done", 64'(done_cnt), 64'(snap));
        chk("rst_no_goidle", 64'(goidle_cnt), 64'd0);

        // After reset the round-robin pointer favours A again
        expect_cmd(1'b0, 16'h0035, 40'h0A00000005);
        expect_cmd(1'b1, 16'h0036, 40'h0B00000006);
        pulse(1'b1, 1'b1, 16'h0035, 40'h0A00000005, 16'h0036, 40'h0B00000006);
        wait_idle();

        chk("results_left", 64'(rq.size()), 64'd0);
        chk("issues_left", 64'(iq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
